// File: rtl/mod_gold_pkg.sv
// Shared constants, word-split type and fold helper for the Goldilocks
// reducer (p = 2^64 - 2^32 + 1).
package mod_gold_pkg;

    localparam logic [63:0] GOLD_P   = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] GOLD_EPS = 64'h0000_0000_FFFF_FFFF;  // 2^64 mod p

    // 192-bit operand as six 32-bit words, a most significant
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
    } gold_words_t;

    // Reduce a 65-bit value (< 2^65) to [0, p-1].
    // Bit 64 folds in as 2^32 - 1. The fold sum is kept as a carry plus 64
    // bits: when the carry is set the true value is 2^64 + s, and
    // (2^64 + s) - p equals s - p taken modulo 2^64, so one subtract covers
    // both the carry case and s >= p.
    function automatic logic [63:0] gold_fold65(input logic [64:0] t);
        logic [63:0] s;
        logic        c;
        {c, s} = {1'b0, t[63:0]} + {1'b0, (t[64] ? GOLD_EPS : 64'd0)};
        if (c || (s >= GOLD_P)) begin
            gold_fold65 = s - GOLD_P;
        end else begin
            gold_fold65 = s;
        end
    endfunction

endpackage

// File: rtl/mod_gold_reduce_pipe_stage_reg.sv
// Valid/ready pipeline register with bubble-collapsing ready.
module mod_gold_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         down_ready,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // Stage accepts whenever it is empty or its contents move on this cycle
    always_comb begin
        ready = ~valid | down_ready;
    end

    // Load valid and payload when ready; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mod_gold_reduce_pipe.sv
// Elastic 3-stage reducer of a wide operand modulo p = 2^64 - 2^32 + 1,
// carrying a sideband tag. Optional perf counters: MOD_GOLD_PERF_CNT_EN.
module mod_gold_reduce_pipe
    import mod_gold_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 192,
    parameter int unsigned P_WIDTH  = 64,
    parameter int unsigned TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]    out_tag
`ifdef MOD_GOLD_PERF_CNT_EN
    ,
    output logic [31:0]         acc_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int unsigned S1_W = TAG_W + 130;
    localparam int unsigned S2_W = TAG_W + 128;
    localparam int unsigned S3_W = TAG_W + 64;

    generate
        if (P_WIDTH != 64) begin : g_pw_chk
            $error("mod_gold_reduce_pipe: P_WIDTH must be 64");
        end
        if (IN_WIDTH != 128 && IN_WIDTH != 192) begin : g_iw_chk
            $error("mod_gold_reduce_pipe: IN_WIDTH must be 128 or 192");
        end
        if (TAG_W < 1) begin : g_tw_chk
            $error("mod_gold_reduce_pipe: TAG_W must be at least 1");
        end
    endgenerate

    logic [191:0]      op_ext;
    gold_words_t       w;
    logic [64:0]       t1, t4;
    logic [S1_W-1:0]   s1_d, s1_q;
    logic [S2_W-1:0]   s2_d, s2_q;
    logic [S3_W-1:0]   s3_d, s3_q;
    logic              v1, v2, v3;
    logic              rdy1, rdy2, rdy3;
    logic [63:0]       t1r, t4r, diff, r;
    logic              borrow;

    // Stage 1 input: split operand (a, b zero for 128-bit) and form both sums
    always_comb begin
        op_ext = 192'(in_data);
        w      = gold_words_t'(op_ext);
        t1     = {1'b0, w.e, w.f} + {1'b0, w.d, w.a};
        t4     = {1'b0, w.b, w.c} + {1'b0, w.a, w.d};
        s1_d   = {in_tag, t1, t4};
    end

    // Stage 2 input: fold both 65-bit sums to canonical residues
    always_comb begin
        s2_d = {s1_q[S1_W-1 -: TAG_W],
                gold_fold65(s1_q[129:65]),
                gold_fold65(s1_q[64:0])};
    end

    // Stage 3 input: modular difference, add p back on borrow
    always_comb begin
        t1r            = s2_q[127:64];
        t4r            = s2_q[63:0];
        {borrow, diff} = {1'b0, t1r} - {1'b0, t4r};
        r              = borrow ? (diff + GOLD_P) : diff;
        s3_d           = {s2_q[S2_W-1 -: TAG_W], r};
    end

    mod_gold_stage_reg #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (s1_d),
        .down_ready (rdy2),
        .ready      (rdy1),
        .valid      (v1),
        .data       (s1_q)
    );

    mod_gold_stage_reg #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v1),
        .in_data    (s2_d),
        .down_ready (rdy3),
        .ready      (rdy2),
        .valid      (v2),
        .data       (s2_q)
    );

    mod_gold_stage_reg #(.W(S3_W)) u_s3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v2),
        .in_data    (s3_d),
        .down_ready (out_ready),
        .ready      (rdy3),
        .valid      (v3),
        .data       (s3_q)
    );

    // Output mapping from the last stage
    always_comb begin
        in_ready  = rdy1;
        out_valid = v3;
        out_data  = s3_q[P_WIDTH-1:0];
        out_tag   = s3_q[S3_W-1 -: TAG_W];
    end

`ifdef MOD_GOLD_PERF_CNT_EN
    // Count input handshakes and output stall cycles, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (in_valid && rdy1) begin
                acc_cnt <= acc_cnt + 32'd1;
            end
            if (v3 && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mod_gold_reduce_pipe.sv
// Directed and random checks of mod_gold_reduce_pipe (IN_WIDTH=192, TAG_W=4).
module tb_mod_gold_reduce_pipe;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] in_data;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [3:0]   out_tag;
`ifdef MOD_GOLD_PERF_CNT_EN
    logic [31:0]  acc_cnt;
    logic [31:0]  stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mod_gold_reduce_pipe #(.IN_WIDTH(192), .P_WIDTH(64), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef MOD_GOLD_PERF_CNT_EN
        ,
        .acc_cnt   (acc_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Bit-serial Horner reduction, independent of the word-split identity
    function automatic logic [63:0] ref_mod(input logic [191:0] x);
        logic [64:0] acc;
        acc = '0;
        for (int i = 191; i >= 0; i--) begin
            acc = {acc[63:0], x[i]};
            if (acc >= {1'b0, P}) acc = acc - {1'b0, P};
        end
        return acc[63:0];
    endfunction

    // Send one operand into an empty pipe and wait for its result
    task automatic run_one(input logic [191:0] a, input logic [3:0] tg,
                           output logic [63:0] res, output logic [3:0] rtg,
                           output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = a; in_tag = tg; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; in_tag = '0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
        rtg = out_tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_tag = '0;
        #12;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (out_data !== 64'd0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
        vectors++; if (out_tag !== 4'd0) begin miscompares++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [191:0] ops [10];
        logic [63:0]  exps[10];
        logic [63:0]  res;
        logic [3:0]   rtg;
        int           lat;
        ops[0] = 192'd0;                               exps[0] = 64'd0;
        ops[1] = {128'd0, P};                          exps[1] = 64'd0;
        ops[2] = 192'd1 << 64;                         exps[2] = 64'h0000_0000_FFFF_FFFF;
        ops[3] = 192'd1 << 96;                         exps[3] = 64'hFFFF_FFFF_0000_0000;
        ops[4] = 192'd1 << 160;                        exps[4] = 64'hFFFF_FFFE_0000_0002;
        ops[5] = 192'd1 << 128;                        exps[5] = 64'hFFFF_FFFE_0000_0001;
        ops[6] = '1;                                   exps[6] = 64'd0;
        ops[7] = {64'd0, {128{1'b1}}};                 exps[7] = 64'hFFFF_FFFE_0000_0000;
        ops[8] = {96'd0, P, 32'd0};                    exps[8] = 64'd0;
        ops[9] = {128'd0, 64'hFFFF_FFFF_FFFF_FFFF};    exps[9] = 64'h0000_0000_FFFF_FFFE;
        for (int i = 0; i < 10; i++) begin
            run_one(ops[i], 4'(i + 3), res, rtg, lat);
            vectors++; if (res !== exps[i]) begin miscompares++; $display("FAIL directed_data[%0d] got %h want %h", i, res, exps[i]); end
            vectors++; if (rtg !== 4'(i + 3)) begin miscompares++; $display("FAIL directed_tag[%0d] got %h want %h", i, rtg, 4'(i + 3)); end
            vectors++; if (lat !== 3) begin miscompares++; $display("FAIL directed_latency[%0d] got %0d want 3", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int got = 0;
        int cyc = 0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (accepted < 6);
            in_data   = {96'd0, 32'(accepted + 1), 32'd0, 32'(accepted + 1)};
            in_tag    = 4'(accepted + 1);
            #1;
            if (cyc == 4) begin
                vectors++; if (accepted !== 3) begin miscompares++; $display("FAIL b2b_accepts got %0d want 3", accepted); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready got %0b want 0", in_ready); end
                vectors++; if (out_valid !== 1'b1 || out_tag !== 4'd1) begin miscompares++; $display("FAIL b2b_held got v=%0b tag=%h want v=1 tag=1", out_valid, out_tag); end
            end
            if (out_valid && out_ready) begin
                vectors++; if (out_tag !== 4'(got + 1)) begin miscompares++; $display("FAIL b2b_tag[%0d] got %h want %h", got, out_tag, 4'(got + 1)); end
                vectors++; if (out_data !== {32'(got + 1), 32'd0}) begin miscompares++; $display("FAIL b2b_data[%0d] got %h want %h", got, out_data, {32'(got + 1), 32'd0}); end
                got++;
            end
            if (in_valid && in_ready) accepted++;
            cyc++;
        end
        vectors++; if (got !== 6) begin miscompares++; $display("FAIL b2b_count got %0d want 6", got); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got %0b want 0", out_valid); end
    endtask

    task automatic test_midreset();
        logic [63:0] res;
        logic [3:0]  rtg;
        int          lat;
        int          stale = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 192'd7; in_tag = 4'hA;
        @(negedge clk);
        in_data = 192'd9; in_tag = 4'hB;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got %0b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_async got %0b want 0", out_valid); end
        vectors++; if (out_data !== 64'd0) begin miscompares++; $display("FAIL midrst_data got %h want 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        vectors++; if (stale !== 0) begin miscompares++; $display("FAIL midrst_stale got %0d want 0", stale); end
        run_one((192'd1 << 96) + 192'd5, 4'h5, res, rtg, lat);
        vectors++; if (res !== 64'd4 || rtg !== 4'h5 || lat !== 3) begin miscompares++; $display("FAIL midrst_after got %h/%h/%0d want 4/5/3", res, rtg, lat); end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [63:0] exp_d[$];
        logic [3:0]  exp_t[$];
        logic [63:0] ed;
        logic [3:0]  et;
        int sent = 0;
        int rcvd = 0;
        int stalls = 0;
        int cyc = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        while ((sent < N || rcvd < N) && cyc < 80000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = (sent < N) && ($urandom_range(0, 9) < 7);
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 15) == 0) in_data = '1;
            in_tag    = 4'($urandom());
            #1;
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rand_extra got tag %h want none", out_tag);
                end else begin
                    ed = exp_d.pop_front();
                    et = exp_t.pop_front();
                    vectors++; if (out_data !== ed) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", rcvd, out_data, ed); end
                    vectors++; if (out_tag !== et) begin miscompares++; $display("FAIL rand_tag[%0d] got %h want %h", rcvd, out_tag, et); end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_d.push_back(ref_mod(in_data));
                exp_t.push_back(in_tag);
                sent++;
            end
            cyc++;
        end
        vectors++; if (rcvd !== N || sent !== N) begin miscompares++; $display("FAIL rand_count got sent=%0d rcvd=%0d want %0d", sent, rcvd, N); end
`ifdef MOD_GOLD_PERF_CNT_EN
        vectors++; if (acc_cnt !== 32'(N)) begin miscompares++; $display("FAIL perf_acc got %0d want %0d", acc_cnt, N); end
        vectors++; if (stall_cnt !== 32'(stalls)) begin miscompares++; $display("FAIL perf_stall got %0d want %0d", stall_cnt, stalls); end
`endif
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
